// File: rtl/execute_stage.sv
// Execute stage of a five-stage RISC-V style pipeline: ID/EX register, operand
// forwarding, ALU, branch/jump resolution and the EX/MEM register.
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic             JALRctrlD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] PCD,
    input  logic [WIDTH-1:0] ImmExtD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             FlushE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic             PCSrcE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             ResultSrcE0,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [4:0]       RdM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M
);

    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic [2:0]       alu_control;
        logic             alu_src;
        logic             jalr;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] imm_ext;
        logic [WIDTH-1:0] pc_plus4;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
    } id_ex_t;

    typedef struct packed {
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write;
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] write_data;
        logic [4:0]       rd;
        logic [WIDTH-1:0] pc_plus4;
    } ex_mem_t;

    id_ex_t           id_ex_d, id_ex_q;
    ex_mem_t          ex_mem_d, ex_mem_q;
    logic [WIDTH-1:0] src_a_e;
    logic [WIDTH-1:0] write_data_e;
    logic [WIDTH-1:0] src_b_e;
    logic [WIDTH-1:0] alu_result_e;
    logic [WIDTH-1:0] jalr_sum_e;
    logic             zero_e;

    // A flush turns the next ID/EX value into an all-zero bubble.
    always_comb begin
        id_ex_d = '0;
        if (!FlushE) begin
            id_ex_d.reg_write   = RegWriteD;
            id_ex_d.result_src  = ResultSrcD;
            id_ex_d.mem_write   = MemWriteD;
            id_ex_d.jump        = JumpD;
            id_ex_d.branch      = BranchD;
            id_ex_d.alu_control = ALUControlD;
            id_ex_d.alu_src     = ALUSrcD;
            id_ex_d.jalr        = JALRctrlD;
            id_ex_d.rd1         = RD1D;
            id_ex_d.rd2         = RD2D;
            id_ex_d.pc          = PCD;
            id_ex_d.imm_ext     = ImmExtD;
            id_ex_d.pc_plus4    = PCPlus4D;
            id_ex_d.rs1         = Rs1D;
            id_ex_d.rs2         = Rs2D;
            id_ex_d.rd          = RdD;
        end
    end

    // Forwarding from ALUResultM uses our own EX/MEM register, so a dependent
    // instruction immediately behind its producer needs no stall.
    always_comb begin
        src_a_e      = id_ex_q.rd1;
        write_data_e = id_ex_q.rd2;
        unique case (ForwardAE)
            2'b01:   src_a_e = ResultW;
            2'b10:   src_a_e = ex_mem_q.alu_result;
            default: src_a_e = id_ex_q.rd1;
        endcase
        unique case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = ex_mem_q.alu_result;
            default: write_data_e = id_ex_q.rd2;
        endcase
        src_b_e = id_ex_q.alu_src ? id_ex_q.imm_ext : write_data_e;
    end

    always_comb begin
        alu_result_e = '0;
        unique case (id_ex_q.alu_control)
            3'b000: alu_result_e = src_a_e + src_b_e;
            3'b001: alu_result_e = src_a_e - src_b_e;
            3'b010: alu_result_e = src_a_e & src_b_e;
            3'b011: alu_result_e = src_a_e | src_b_e;
            3'b100: alu_result_e = src_a_e ^ src_b_e;
            3'b101: alu_result_e = {{(WIDTH-1){1'b0}}, ($signed(src_a_e) < $signed(src_b_e))};
            3'b110: alu_result_e = src_a_e << src_b_e[4:0];
            3'b111: alu_result_e = src_a_e >> src_b_e[4:0];
            default: alu_result_e = '0;
        endcase
        zero_e = (alu_result_e == '0);
    end

    always_comb begin
        jalr_sum_e = src_a_e + id_ex_q.imm_ext;
        PCSrcE     = id_ex_q.jump | (id_ex_q.branch & zero_e);
        if (id_ex_q.jalr) begin
            PCTargetE = {jalr_sum_e[WIDTH-1:1], 1'b0};
        end else begin
            PCTargetE = id_ex_q.pc + id_ex_q.imm_ext;
        end
    end

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.result_src = id_ex_q.result_src;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.alu_result = alu_result_e;
        ex_mem_d.write_data = write_data_e;
        ex_mem_d.rd         = id_ex_q.rd;
        ex_mem_d.pc_plus4   = id_ex_q.pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign Rs1E        = id_ex_q.rs1;
    assign Rs2E        = id_ex_q.rs2;
    assign RdE         = id_ex_q.rd;
    assign ResultSrcE0 = id_ex_q.result_src[0];
    assign RegWriteM   = ex_mem_q.reg_write;
    assign MemWriteM   = ex_mem_q.mem_write;
    assign ResultSrcM  = ex_mem_q.result_src;
    assign RdM         = ex_mem_q.rd;
    assign ALUResultM  = ex_mem_q.alu_result;
    assign WriteDataM  = ex_mem_q.write_data;
    assign PCPlus4M    = ex_mem_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ResultSrcE0;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int vectors     = 0;
    int miscompares = 0;

    execute_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_d();
        RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0; JALRctrlD = 0;
        ResultSrcD = 0; ALUControlD = 0;
        RD1D = 0; RD2D = 0; PCD = 0; ImmExtD = 0; PCPlus4D = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0;
        FlushE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic        use_imm;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t alu_tab[10];

    initial begin
        alu_tab[0] = '{32'hFFFF_FFFF, 32'h2,         3'b000, 1'b0, 32'h1};
        alu_tab[1] = '{32'h3,         32'h5,         3'b001, 1'b0, 32'hFFFF_FFFE};
        alu_tab[2] = '{32'h0000_F0F0, 32'h0000_FF00, 3'b010, 1'b0, 32'h0000_F000};
        alu_tab[3] = '{32'h0000_F0F0, 32'h0000_0F0F, 3'b011, 1'b0, 32'h0000_FFFF};
        alu_tab[4] = '{32'h0000_00FF, 32'h0000_000F, 3'b100, 1'b0, 32'h0000_00F0};
        alu_tab[5] = '{32'hFFFF_FFFF, 32'h1,         3'b101, 1'b0, 32'h1};
        alu_tab[6] = '{32'h1,         32'hFFFF_FFFF, 3'b101, 1'b0, 32'h0};
        alu_tab[7] = '{32'h1,         32'h23,        3'b110, 1'b0, 32'h8};
        alu_tab[8] = '{32'h8000_0000, 32'd31,        3'b111, 1'b1, 32'h1};
        alu_tab[9] = '{32'h8000_0000, 32'd4,         3'b111, 1'b0, 32'h0800_0000};

        // Reset with garbage on the D side must still leave everything at zero.
        clr_d();
        rst = 1;
        RegWriteD = 1; MemWriteD = 1; JumpD = 1; RD1D = 32'h55; PCD = 32'h40;
        ImmExtD = 32'h8; RdD = 5'd4;
        tick();
        tick();
        chk("rst_pcsrc", {31'b0, PCSrcE}, 32'h0);
        chk("rst_pctarget", PCTargetE, 32'h0);
        chk("rst_regwrite_m", {31'b0, RegWriteM}, 32'h0);
        chk("rst_memwrite_m", {31'b0, MemWriteM}, 32'h0);
        chk("rst_aluresult_m", ALUResultM, 32'h0);
        chk("rst_rd_e", {27'b0, RdE}, 32'h0);
        rst = 0;

        // ADD with two-cycle latency to the M outputs.
        clr_d();
        RD1D = 5; RD2D = 7; RdD = 3; RegWriteD = 1; ResultSrcD = 2'b01; Rs1D = 5'd1; Rs2D = 5'd2;
        tick();
        chk("add_rd_e", {27'b0, RdE}, 32'd3);
        chk("add_rs1_e", {27'b0, Rs1E}, 32'd1);
        chk("add_rs2_e", {27'b0, Rs2E}, 32'd2);
        chk("add_rsrc_e0", {31'b0, ResultSrcE0}, 32'h1);
        chk("add_regwrite_m_early", {31'b0, RegWriteM}, 32'h0);
        clr_d();
        tick();
        chk("add_result_m", ALUResultM, 32'd12);
        chk("add_rd_m", {27'b0, RdM}, 32'd3);
        chk("add_regwrite_m", {31'b0, RegWriteM}, 32'h1);
        chk("add_rsrc_m", {30'b0, ResultSrcM}, 32'h1);

        // BEQ taken then not taken.
        clr_d();
        RD1D = 9; RD2D = 9; ALUControlD = 3'b001; BranchD = 1; PCD = 32'h100; ImmExtD = 32'h20;
        tick();
        chk("beq_taken", {31'b0, PCSrcE}, 32'h1);
        chk("beq_target", PCTargetE, 32'h120);
        RD2D = 8;
        tick();
        chk("beq_not_taken", {31'b0, PCSrcE}, 32'h0);

        // JALR clears bit 0 of the sum; PC+4 reaches M a cycle later.
        clr_d();
        JumpD = 1; JALRctrlD = 1; RD1D = 32'h203; ImmExtD = 4; PCD = 32'h40; PCPlus4D = 32'h44;
        tick();
        chk("jalr_pcsrc", {31'b0, PCSrcE}, 32'h1);
        chk("jalr_target", PCTargetE, 32'h206);
        clr_d();
        tick();
        chk("jalr_pcplus4_m", PCPlus4M, 32'h44);

        // Forwarding: producer writes 10 to x5, consumer adds immediate 1.
        clr_d();
        RD1D = 10; ALUSrcD = 1; RdD = 5; RegWriteD = 1;
        tick();
        clr_d();
        ALUSrcD = 1; ImmExtD = 1; Rs1D = 5; RdD = 6; RegWriteD = 1;
        tick();
        chk("fwd_producer_m", ALUResultM, 32'd10);
        ForwardAE = 2'b10;
        tick();
        chk("fwd_a_mem", ALUResultM, 32'd11);
        ForwardAE = 2'b01; ResultW = 32'd40;
        tick();
        chk("fwd_a_wb", ALUResultM, 32'd41);
        ForwardAE = 2'b11;
        tick();
        chk("fwd_a_11_regfile", ALUResultM, 32'd1);
        ForwardBE = 2'b01; ResultW = 32'd40;
        tick();
        chk("fwd_b_wb", WriteDataM, 32'd40);
        ForwardBE = 2'b10;
        tick();
        chk("fwd_b_mem", WriteDataM, 32'd1);

        // Flushed branch/store becomes a bubble.
        clr_d();
        tick();
        BranchD = 1; MemWriteD = 1; RegWriteD = 1; FlushE = 1;
        tick();
        chk("flush_pcsrc", {31'b0, PCSrcE}, 32'h0);
        clr_d();
        tick();
        chk("flush_memwrite_m", {31'b0, MemWriteM}, 32'h0);
        chk("flush_regwrite_m", {31'b0, RegWriteM}, 32'h0);

        // Flush alongside a taken branch already in EX.
        clr_d();
        RD1D = 9; RD2D = 9; ALUControlD = 3'b001; BranchD = 1; PCD = 32'h100; ImmExtD = 32'h20;
        tick();
        FlushE = 1;
        #1;
        chk("flush_same_cycle_pcsrc", {31'b0, PCSrcE}, 32'h1);
        tick();
        chk("flush_after_pcsrc", {31'b0, PCSrcE}, 32'h0);
        chk("flush_after_target", PCTargetE, 32'h0);

        // Reset while both registers hold live instructions.
        clr_d();
        RD1D = 1; RD2D = 2; RegWriteD = 1; MemWriteD = 1; RdD = 7;
        tick();
        clr_d();
        JumpD = 1; PCD = 32'h10; ImmExtD = 4; RdD = 9; RegWriteD = 1;
        tick();
        chk("pre_rst_pcsrc", {31'b0, PCSrcE}, 32'h1);
        chk("pre_rst_regwrite_m", {31'b0, RegWriteM}, 32'h1);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_pcsrc", {31'b0, PCSrcE}, 32'h0);
        chk("mid_rst_target", PCTargetE, 32'h0);
        chk("mid_rst_regwrite_m", {31'b0, RegWriteM}, 32'h0);
        chk("mid_rst_memwrite_m", {31'b0, MemWriteM}, 32'h0);
        chk("mid_rst_aluresult_m", ALUResultM, 32'h0);
        chk("mid_rst_rd_e", {27'b0, RdE}, 32'h0);
        chk("mid_rst_rd_m", {27'b0, RdM}, 32'h0);

        // ALU operation table.
        for (int i = 0; i < 10; i++) begin
            clr_d();
            RD1D = alu_tab[i].a;
            ALUControlD = alu_tab[i].ctl;
            ALUSrcD = alu_tab[i].use_imm;
            if (alu_tab[i].use_imm) ImmExtD = alu_tab[i].b;
            else RD2D = alu_tab[i].b;
            tick();
            clr_d();
            tick();
            chk($sformatf("alu_op%0d", i), ALUResultM, alu_tab[i].exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
